clk_freq_meter: RTL

//  Measures the frequency of a derived clock or slow periodic signal by counting its

---
 rtl/clk_freq_meter_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/clk_freq_meter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter.
// Holds the FSM state encoding and the default window/expectation
// values for checking PLL/divider taps against the 16 MHz core clock.
package clk_freq_meter_pkg;

  // Defaults: 100 us gate at 16 MHz, expecting a 1 MHz tap.
  localparam int unsigned DEF_GATE_CYCLES = 1600;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_EXPECT      = 100;
  localparam int unsigned DEF_TOL         = 2;

  // FSM state encoding: IDLE, ARM, COUNT, REPORT.
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ARM    = 2'd1;
  localparam state_t COUNT  = 2'd2;
  localparam state_t REPORT = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Reusable for any asynchronous single-bit input.
// Ports:
//   clk     - sampling clock
//   resetn  - asynchronous active-low reset
//   d_async - asynchronous input
//   rise    - one-cycle pulse per synchronized rising edge
//             (combinational from the last flop pair)
module sync_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic d_async,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // sync1/sync2 resolve metastability; sync2_d holds the previous level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= d_async;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/clk_freq_meter.sv
// Clock frequency meter: counts rising edges of meas_in over a window of
// GATE_CYCLES clk cycles and reports the count plus a range check
// against EXPECT +/- TOL.
// Optional feature macro: CLK_FREQ_METER_STICKY_ERR_EN enables the
// sticky out-of-range flag; when undefined err_sticky is tied low.
// Ports:
//   clk        - system clock (only clock domain)
//   resetn     - asynchronous active-low reset
//   enable     - run back-to-back measurements while high
//   meas_in    - signal under test, asynchronous to clk
//   err_clr    - clears err_sticky
//   count      - edges counted in the last completed window
//   valid      - one-cycle pulse when count/in_range update
//   in_range   - last count within EXPECT +/- TOL
//   err_sticky - sticky out-of-range flag
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned EXPECT      = DEF_EXPECT,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             meas_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             in_range,
  output logic             err_sticky
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  state_t            state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              meas_rise;
  logic [CMP_W-1:0]  edge_ext;
  logic [CMP_W-1:0]  expect_ext;
  logic [CMP_W-1:0]  diff_c;
  logic              in_range_c;

  sync_edge_det u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .d_async (meas_in),
    .rise    (meas_rise)
  );

  // Absolute distance from EXPECT, one bit wider so neither side can wrap.
  assign edge_ext   = {1'b0, edge_cnt};
  assign expect_ext = CMP_W'(EXPECT);
  assign diff_c     = (edge_ext >= expect_ext) ? (edge_ext - expect_ext)
                                               : (expect_ext - edge_ext);
  assign in_range_c = (diff_c <= CMP_W'(TOL));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; dropping enable mid-window aborts without a report.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM:     state_nxt = COUNT;
      COUNT: begin
        if (!enable)                   state_nxt = IDLE;
        else if (gate_cnt == GATE_LAST) state_nxt = REPORT;
      end
      REPORT:  state_nxt = enable ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters and registered results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      count    <= '0;
      valid    <= 1'b0;
      in_range <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
        COUNT: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          // Saturate rather than wrap so a runaway input never reads as slow.
          if (meas_rise && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          count    <= edge_cnt;
          in_range <= in_range_c;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_FREQ_METER_STICKY_ERR_EN
  // A failing report wins over a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_sticky <= 1'b0;
    end else if ((state == REPORT) && !in_range_c) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sticky     = 1'b0;
`endif

endmodule
